// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage
package fetch_unit_pkg;

    // Bytes per instruction word; the fetch PC advances by this amount
    localparam int SIZE_WORD = 4;

    localparam int INST_WIDTH = 32;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // IDLE: nothing outstanding, WAIT: one request outstanding,
    // DROP: the outstanding response belongs to a flushed path
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of {pc, inst} pairs with flush
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against pops of an empty queue and pushes into a full one
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    end

    assign head_data = mem[rd_ptr];

    // Pointer, count and storage update; flush discards everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multi-cycle instruction fetch stage with redirect flush
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                      ADDRESS_BITS = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = ADDRESS_BITS'(RESET_PC_DEFAULT),
    parameter int                      QUEUE_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req_valid,
    output logic [ADDRESS_BITS-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_resp_valid,
    input  logic [INST_WIDTH-1:0]   imem_resp_data,
    output logic                    if_valid,
    output logic [ADDRESS_BITS-1:0] if_pc,
    output logic [INST_WIDTH-1:0]   if_inst,
    input  logic                    id_ready,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_BITS-1:0] redirect_pc,
    input  logic                    halt,
    output logic                    fetch_fault
);

    localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam int ENTRY_W = ADDRESS_BITS + INST_WIDTH;

    fetch_state_t            state;
    logic [ADDRESS_BITS-1:0] fetch_pc;
    logic [ADDRESS_BITS-1:0] req_pc;
    logic [CNT_W-1:0]        count;
    logic [ENTRY_W-1:0]      head_data;
    logic                    req_fire;
    logic                    q_push;
    logic                    q_pop;

    // Request only when idle and a queue slot is guaranteed for the response
    always_comb begin
        imem_req_valid = !rst && (state == ST_IDLE) && !halt && !fetch_fault &&
                         !redirect_valid && (count < CNT_W'(QUEUE_DEPTH));
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        q_push         = (state == ST_WAIT) && imem_resp_valid && !redirect_valid;
        q_pop          = if_valid && id_ready && !redirect_valid;
    end

    // Fetch FSM: owns the PC, tracks the outstanding request, handles redirects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                fetch_fault <= 1'b1;
            end
            // An in-flight response is stale; drop it whenever it shows up
            case (state)
                ST_WAIT: state <= imem_resp_valid ? ST_IDLE : ST_DROP;
                ST_DROP: state <= imem_resp_valid ? ST_IDLE : ST_DROP;
                default: state <= ST_IDLE;
            endcase
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + ADDRESS_BITS'(SIZE_WORD);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (imem_resp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data ({req_pc, imem_resp_data}),
        .pop       (q_pop),
        .head_data (head_data),
        .count     (count)
    );

    assign if_valid = (count != '0);
    assign if_pc    = head_data[ENTRY_W-1:INST_WIDTH];
    assign if_inst  = head_data[INST_WIDTH-1:0];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Multi-cycle instruction fetch stage that sits between the PC/instruction-memory path and the decoder. It is the first step toward a pipelined core with a variable-latency instruction memory. It owns the fetch PC, issues one word request at a time over a valid/ready bus, and buffers returned {pc, instruction} pairs in a small queue. The decoder consumes the queue through a valid/ready handshake; branch/jump redirects flush the queue and discard any stale in-flight response.

Parameters:
ADDRESS_BITS, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, fetch address after reset
QUEUE_DEPTH, 4, entries in instruction queue; power of 2, >= 2

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
imem_req_valid  output  1  request presented to instruction memory
imem_req_addr  output  ADDRESS_BITS  word-aligned fetch address
imem_req_ready  input  1  memory accepts request this cycle
imem_resp_valid  input  1  response data valid (at most one per accepted request)
imem_resp_data  input  32  instruction word
if_valid  output  1  queue head valid to decoder
if_pc  output  ADDRESS_BITS  PC of queue head
if_inst  output  32  instruction of queue head
id_ready  input  1  decoder consumes head this cycle
redirect_valid  input  1  branch/jal/jalr taken; flush and refetch
redirect_pc  input  ADDRESS_BITS  redirect target
halt  input  1  stop issuing new requests
fetch_fault  output  1  sticky: misaligned redirect target seen

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, queue empty, state IDLE, fetch_fault=0; outputs imem_req_valid=0, if_valid=0, if_pc=0, if_inst=0.
- States: IDLE (nothing outstanding), WAIT (one request outstanding), DROP (outstanding response to discard).
- imem_req_valid = (state==IDLE) & ~halt & ~fetch_fault & ~redirect_valid & (count < QUEUE_DEPTH). The signal is combinational from registered state. imem_req_addr = fetch_pc.
- Accept (req_valid & req_ready): req_pc <= fetch_pc; fetch_pc <= fetch_pc+4, wrapping mod 2^ADDRESS_BITS; IDLE->WAIT.
- Holding a request slot is conditional on count < DEPTH, so a push can never overflow the queue.
- WAIT & resp_valid: push {req_pc, resp_data}; ->IDLE. No new request is issued in the same cycle, so peak throughput is 1 instruction per 2 cycles.
- Dequeue: if_valid = (count != 0). Head pops on if_valid & id_ready. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, same edge):
  - queue flushed (count=0; a simultaneous pop and push are both ignored);
  - fetch_pc <= redirect_pc;
  - state WAIT without resp_valid -> DROP; WAIT with resp_valid -> response discarded, ->IDLE; DROP stays DROP; IDLE stays IDLE.
- DROP & resp_valid: discard data, ->IDLE.
- Misaligned redirect (redirect_pc[1:0] != 0): fetch_fault <= 1 (sticky until rst); fetch_pc still loaded; no further requests. The queue may still drain only if it was not flushed; in practice it is flushed.
- halt: blocks new requests only. The outstanding response completes, and the queue still drains to the decoder.
- resp_valid in IDLE is ignored. This is a protocol violation, flagged by a bench assertion.
- if_pc/if_inst are stable while if_valid=1 and id_ready=0.

Decomposition:
- Shared package/defines: fetch state encoding (IDLE/WAIT/DROP), RESET_PC default, instruction width 32; reuse existing SIZE_WORD define.
- One sub-module: fetch_queue, a synchronous FIFO of {pc, inst}.
  - Ports: clk, rst, flush, push, push_data, pop, head_data, count.
  - Pointers wrap mod QUEUE_DEPTH; count width clog2(DEPTH)+1.

Test Plan:
- Reset, zero-latency memory (ready=1, resp next cycle), id_ready=1 -> requests at 0x0, 0x4, 0x8; if_pc sequence 0x0, 0x4, 0x8 with matching words; one request every 2 cycles.
- id_ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC) then imem_req_valid=0. Raise id_ready -> drains in order and fetch resumes at 0x10.
- Memory latency 3 cycles; redirect_valid with redirect_pc=0x100 in the middle of the wait -> state DROP, stale response discarded, queue empty, next request addr=0x100, first if_pc=0x100.
- Redirect in the same cycle as resp_valid and id_ready with a non-empty queue -> response and head both dropped, count=0, next request at the target.
- halt=1 while a request is outstanding -> that response is queued, no further requests, queue drains. halt=0 -> fetch resumes at the next sequential PC.
- redirect_pc=0x102 -> fetch_fault=1, no further imem_req_valid; assert rst mid-operation -> fetch_fault=0, first request at RESET_PC.
